// File: rtl/digit_scan_mux_pkg.sv
// Shared types and constants for the 7-segment digit scan driver.
package digit_scan_mux_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX   = 4'd9;
    localparam logic   ANODE_OFF = 1'b1;

    // Width of a counter that has to hold the values 0..n-1. It never returns
    // less than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_scan_mux_lz_mask.sv
// Blank mask for a bank of packed BCD digits. Invalid codes are blanked.
// When lzb_i is set, leading zeros are also blanked, but digit 0 always stays lit.
module digit_scan_mux_lz_mask
    import digit_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    lzb_i,
    output logic [NUM_DIGITS-1:0]   blank_o
);

    logic   upper_zero;
    digit_t code;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        blank_o    = '0;
        upper_zero = 1'b1;
        code       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            code = digits_i[4*k +: 4];
            // NOTE: blocking '=' is deliberate: upper_zero must pass each digit's result down to the next lower one.
            upper_zero = upper_zero && (code == 4'd0);
            blank_o[k] = (code > BCD_MAX) || (lzb_i && upper_zero && (k != 0));
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed scan driver for common-anode 7-segment digits. New values
// are held in a shadow register and move to the display only at frame wrap.
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iLoad,
    input  logic [4*NUM_DIGITS-1:0] iDigits,
    input  logic                    iLzb,
    output logic [3:0]              oDigit,
    output logic [NUM_DIGITS-1:0]   oAnode,
    output logic                    oPending,
    output logic                    oFrame
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int CW = idx_width(REFRESH_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]           div_cnt_q, div_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    digit_t                  digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_q, frame_d;

    logic [NUM_DIGITS-1:0]   blank;
    digit_t                  disp_digits [NUM_DIGITS];
    logic                    terminal;
    logic                    wrap;

    digit_scan_mux_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .digits_i (display_q),
        .lzb_i    (iLzb),
        .blank_o  (blank)
    );

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            disp_digits[k] = display_q[4*k +: 4];
        end
    end

    assign terminal = (div_cnt_q == DIV_LAST);
    assign wrap     = terminal && (idx_q == IDX_LAST);

    always_comb begin
        div_cnt_d = terminal ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        // A load on the wrap cycle skips the shadow and takes effect this frame.
        if (wrap) begin
            if (iLoad) begin
                display_d = iDigits;
                shadow_d  = iDigits;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (iLoad) begin
            shadow_d  = iDigits;
            pending_d = 1'b1;
        end

        digit_d = disp_digits[idx_q];
        anode_d = {NUM_DIGITS{ANODE_OFF}};
        if (!blank[idx_q]) begin
            anode_d[idx_q] = ~ANODE_OFF;
        end
        frame_d = wrap;
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked branch and stays out of the sensitivity list.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            display_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            digit_q   <= '0;
            anode_q   <= {NUM_DIGITS{ANODE_OFF}};
            frame_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' for all state, so every register samples the values from before the edge.
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            digit_q   <= digit_d;
            anode_q   <= anode_d;
            frame_q   <= frame_d;
        end
    end

    assign oDigit   = digit_q;
    assign oAnode   = anode_q;
    assign oPending = pending_q;
    assign oFrame   = frame_q;

endmodule
